mips_if_fetch: RTL and testbench
================================

# mips_if_fetch

Instruction-fetch stage for the 5-stage MIPS pipeline: owns the program counter, talks to instruction memory through a req/ready handshake, and produces the PC+4, instruction, flush and write-enable inputs of the IF/ID register. It is the writer side of IF/ID.
- Absorbs memory wait states, hazard-unit stalls and ID-stage branch redirects.
- Presents IF/ID with either a valid instruction, a bubble (flush, instruction 0 = NOP), or a hold.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  pipeline clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- PCWrite  in  1  from hazard unit; 0 = stall (PC and IF/ID hold).
- BranchTaken  in  1  from ID; taken branch/jump resolved this cycle.
- BranchTarget  in  32  redirect address; bits [1:0] ignored.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  32  fetch address = PC; bits [1:0] always 0.
- IMemReady  in  1  memory accepts and returns data this cycle (only meaningful with IMemReq=1).
- IMemRData  in  32  instruction word, valid when IMemReq & IMemReady.
- PCsum  out  32  PC+4 of the instruction presented, to IF/ID.
- Instruction  out  32  instruction presented to IF/ID.
- IF_FLUSH  out  1  IF/ID loads a bubble this edge.
- IF_IDWrite  out  1  IF/ID write enable; equals PCWrite.

## Operation
- Registers:
  - PC (32).
  - TgtReg (32).
  - HoldReg (32).
  - State ∈ {FETCH, HOLD, KILL}.
- Handshake: once IMemReq=1, IMemAddr stays stable until the cycle with IMemReady=1; there is never more than one request outstanding.
- **FETCH**, IMemReq=1:
  - BranchTaken & PCWrite & IMemReady:
    - PC<=BranchTarget&~3.
    - IF_FLUSH=1.
    - Stay in FETCH.
  - BranchTaken & PCWrite & !IMemReady:
    - TgtReg<=BranchTarget&~3.
    - IF_FLUSH=1.
    - Go to KILL.
  - !BranchTaken & IMemReady & PCWrite:
    - Instruction=IMemRData.
    - IF_FLUSH=0.
    - PC<=PC+4.
  - !BranchTaken & IMemReady & !PCWrite:
    - HoldReg<=IMemRData.
    - Go to HOLD.
    - PC unchanged.
  - !IMemReady & PCWrite, no branch: IF_FLUSH=1 (bubble).
  - !IMemReady & !PCWrite: IF_FLUSH=0.
- **HOLD**, IMemReq=0, Instruction=HoldReg:
  - PCWrite & BranchTaken:
    - Discard HoldReg.
    - PC<=target.
    - IF_FLUSH=1.
    - Go to FETCH.
  - PCWrite & !BranchTaken:
    - IF_FLUSH=0.
    - PC<=PC+4.
    - Go to FETCH.
  - !PCWrite: remain.
- **KILL**, IMemReq=1, address = old PC, IF_FLUSH=PCWrite:
  - On IMemReady: discard data, PC<=TgtReg, go to FETCH.
  - BranchTaken is ignored in KILL, because ID holds a bubble.
- BranchTaken is ignored whenever PCWrite=0. The hazard unit re-asserts it after the stall.
- IF_FLUSH is never 1 while PCWrite=0, because flush has priority inside IF/ID and would destroy a stalled instruction.
- PCsum = PC+4, computed modulo 2^32. PC 32'hFFFF_FFFC wraps to 0.
- Instruction equals IMemRData in FETCH/KILL and HoldReg in HOLD. In FETCH/KILL it is don't-care whenever IF_FLUSH=1; in HOLD it is don't-care whenever IF_FLUSH=1 or PCWrite=0.

## Timing
- Reset (RST=1, async):
  - PC=RESET_PC.
  - State=FETCH.
  - TgtReg=0, HoldReg=0.
  - IMemReq=0, IMemAddr=RESET_PC.
  - IF_FLUSH=1, IF_IDWrite=PCWrite.
- First request occurs in the first cycle after RST falls.
- Zero-wait memory: one instruction per cycle. Instruction at address A reaches IF/ID at the edge ending its ready cycle.
- Each memory wait cycle inserts exactly one bubble, provided PCWrite=1.
- Taken branch:
  - The flush appears in the same cycle as BranchTaken.
  - The target request starts the next cycle (FETCH path) or the cycle after ready (KILL path).
- Reset mid-transaction aborts it. The memory must tolerate request withdrawal on reset.
- Outputs IMemReq, IMemAddr, PCsum and IF_FLUSH are combinational from state/inputs. IF/ID provides the pipeline register.

## Configuration
- MIPS_IF_PERF_EN defined:
  - Adds outputs FetchCount[31:0] and BubbleCount[31:0], both reset to 0.
  - FetchCount increments on every edge with IF_IDWrite=1 & IF_FLUSH=0.
  - BubbleCount increments on every edge with IF_FLUSH=1 & RST=0.
  - Both counters wrap at 2^32.
- MIPS_IF_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, IMemReady=1, PCWrite=1 for 4 cycles -> IMemAddr 0,4,8,12; PCsum 4,8,12,16; IF_FLUSH 0 after first request.
- IMemReady low 2 cycles at addr 8 -> two IF_FLUSH=1 cycles, IMemAddr held at 8, then Instruction=IMemRData, PC->12.
- Ready at addr 4 with PCWrite=0 for 3 cycles -> IMemReq=0, IF_FLUSH=0, IF_IDWrite=0; on release Instruction=captured word, PC->8.
- BranchTaken target 32'h40 while addr 0x10 waiting -> IF_FLUSH=1, KILL until ready, data discarded, next IMemAddr=0x40.
- PC=32'hFFFF_FFFC fetched -> PCsum=0, next IMemAddr=0. RST asserted mid-wait -> IMemReq=0 immediately, PC=RESET_PC.
- With MIPS_IF_PERF_EN: 5 fetches + 2 wait cycles -> FetchCount=5, BubbleCount=2 (+1 reset-release bubble counted only if RST=0).

Source files
------------

// File: rtl/mips_if_fetch.sv
// MIPS IF stage: PC owner, imem req/ready fetch and IF/ID write side.
// Define MIPS_IF_PERF_EN to add FetchCount/BubbleCount counters.
module mips_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWrite,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] PCsum,
  output logic [31:0] Instruction,
  output logic        IF_FLUSH,
  output logic        IF_IDWrite
`ifdef MIPS_IF_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] tgt, tgt_nxt;
  logic [31:0] hold, hold_nxt;
  logic [31:0] pc_al, pc4, br_tgt;
  logic        br;

  assign pc_al  = {pc[31:2], 2'b00};
  assign pc4    = pc_al + 32'd4;
  assign br_tgt = {BranchTarget[31:2], 2'b00};
  assign br     = BranchTaken & PCWrite;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
      pc    <= {RESET_PC[31:2], 2'b00};
      tgt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      tgt   <= tgt_nxt;
      hold  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt;
    hold_nxt  = hold;
    unique case (state)
      FETCH: begin
        if (br) begin
          if (IMemReady) begin
            pc_nxt = br_tgt;
          end else begin
            tgt_nxt   = br_tgt;
            state_nxt = KILL;
          end
        end else if (IMemReady) begin
          if (PCWrite) begin
            pc_nxt = pc4;
          end else begin
            hold_nxt  = IMemRData;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (PCWrite) begin
          pc_nxt    = BranchTaken ? br_tgt : pc4;
          state_nxt = FETCH;
        end
      end
      KILL: begin
        // wrong-path word is dropped; target fetch starts next cycle
        if (IMemReady) begin
          pc_nxt    = tgt;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IMemReq     = 1'b0;
    IMemAddr    = pc_al;
    PCsum       = pc4;
    Instruction = IMemRData;
    IF_IDWrite  = PCWrite;
    IF_FLUSH    = 1'b1;
    if (!RST) begin
      unique case (state)
        FETCH: begin
          IMemReq  = 1'b1;
          IF_FLUSH = PCWrite & (BranchTaken | ~IMemReady);
        end
        HOLD: begin
          Instruction = hold;
          IF_FLUSH    = br;
        end
        KILL: begin
          IMemReq  = 1'b1;
          IF_FLUSH = PCWrite;
        end
        default: IF_FLUSH = PCWrite;
      endcase
    end
  end

`ifdef MIPS_IF_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FetchCount  <= '0;
      BubbleCount <= '0;
    end else begin
      if (IF_IDWrite && !IF_FLUSH)
        FetchCount <= FetchCount + 32'd1;
      if (IF_FLUSH)
        BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_if_fetch.sv
// Self-checking bench for mips_if_fetch: reference model feeds
// an expectation queue that is drained against the DUT each cycle.
module tb_mips_if_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PCWrite = 1'b1;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemRData = '0;
  logic [31:0] PCsum;
  logic [31:0] Instruction;
  logic        IF_FLUSH;
  logic        IF_IDWrite;
`ifdef MIPS_IF_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  mips_if_fetch dut (
    .CLK(CLK),
    .RST(RST),
    .PCWrite(PCWrite),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemReady(IMemReady),
    .IMemRData(IMemRData),
    .PCsum(PCsum),
    .Instruction(Instruction),
    .IF_FLUSH(IF_FLUSH),
    .IF_IDWrite(IF_IDWrite)
`ifdef MIPS_IF_PERF_EN
    ,
    .FetchCount(FetchCount),
    .BubbleCount(BubbleCount)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] sum;
    logic [31:0] ins;
    logic        fl;
    logic        we;
    logic        chk_ins;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_tgt, m_hold, m_fc, m_bc;
  int          m_st;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_tgt  = '0;
    m_hold = '0;
    m_st   = 0;
    m_fc   = '0;
    m_bc   = '0;
  endtask

  task automatic chk_reset();
    chk("rst_req", 32'(IMemReq), 32'd0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_flush", 32'(IF_FLUSH), 32'd1);
    chk("rst_we", 32'(IF_IDWrite), 32'(PCWrite));
  endtask

  task automatic step(input logic pcw, input logic bt,
                      input logic [31:0] t, input logic rdy);
    exp_t e;
    @(negedge CLK);
    RST          = 1'b0;
    PCWrite      = pcw;
    BranchTaken  = bt;
    BranchTarget = t;
    IMemReady    = rdy;
    IMemRData    = memw(IMemAddr);
    e.req  = (m_st != 1);
    e.addr = m_pc;
    e.sum  = m_pc + 32'd4;
    e.we   = pcw;
    case (m_st)
      0:       e.fl = pcw & (bt | ~rdy);
      1:       e.fl = pcw & bt;
      default: e.fl = pcw;
    endcase
    e.ins     = (m_st == 1) ? m_hold : memw(m_pc);
    e.chk_ins = !e.fl && (m_st != 1 || pcw);
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk("req", 32'(IMemReq), 32'(e.req));
    if (e.req) chk("addr", IMemAddr, e.addr);
    chk("pcsum", PCsum, e.sum);
    chk("flush", 32'(IF_FLUSH), 32'(e.fl));
    chk("we", 32'(IF_IDWrite), 32'(e.we));
    if (e.chk_ins) chk("instr", Instruction, e.ins);
    if (pcw && !e.fl) m_fc = m_fc + 1;
    if (e.fl) m_bc = m_bc + 1;
    case (m_st)
      0: begin
        if (pcw && bt) begin
          if (rdy) m_pc = t & ~32'd3;
          else begin
            m_tgt = t & ~32'd3;
            m_st  = 2;
          end
        end else if (rdy) begin
          if (pcw) m_pc = m_pc + 32'd4;
          else begin
            m_hold = memw(m_pc);
            m_st   = 1;
          end
        end
      end
      1: if (pcw) begin
        m_pc = bt ? (t & ~32'd3) : m_pc + 32'd4;
        m_st = 0;
      end
      default: if (rdy) begin
        m_pc = m_tgt;
        m_st = 0;
      end
    endcase
  endtask

  initial begin
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    #1;
    chk_reset();

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("wait_pc", IMemAddr, 32'h8);

    step(0, 0, 0, 1);
    step(0, 1, 32'h100, 1);
    step(0, 0, 0, 0);
    chk("hold_req", 32'(IMemReq), 32'd0);
    step(1, 0, 0, 1);
    chk("hold_ins", Instruction, memw(32'hC));

    step(1, 1, 32'h43, 0);
    chk("br_flush", 32'(IF_FLUSH), 32'd1);
    step(1, 0, 0, 0);
    step(1, 1, 32'h80, 1);
    step(1, 0, 0, 1);
    chk("kill_tgt", IMemAddr, 32'h40);

    step(1, 1, 32'hFFFF_FFFF, 1);
    step(1, 0, 0, 1);
    chk("wrap_sum", PCsum, 32'h0);
    step(1, 0, 0, 1);
    chk("wrap_addr", IMemAddr, 32'h0);

    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    #3;
    RST = 1'b1;
    #1;
    chk_reset();
    model_reset();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0,
           $urandom,
           $urandom_range(0, 2) != 0);
    end

`ifdef MIPS_IF_PERF_EN
    #1;
    chk("fetch_cnt", FetchCount, m_fc);
    chk("bubble_cnt", BubbleCount, m_bc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
